call_return_unit: RTL and testbench

Sequencer directly upstream of the byte-wide `Stack`. Turns 16-bit subroutine CALL/RET requests from the control unit into pairs of single-byte `StackWrite`/`StackRead` strobes. It tracks nesting depth, flags overflow and underflow, and hands the popped return address back to the PC logic. All stack traffic from the core goes through this block.

---
 rtl/call_return_unit.sv | 193 +++++++++++++++++++
 tb/tb_call_return_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_return_unit.sv
// ---------------------------------------------------------------------------
// call_return_unit
//
// Sequencer between the control unit and the byte-wide Stack. A 16-bit CALL
// becomes two single-byte pushes (low byte first, so the high byte ends up
// on top). A RET becomes two single-byte pops (high byte first). The popped
// return address is handed back on PopAddr.
//
// Optional feature macro: CRU_DEPTH_CHECK_EN
//   defined   : frame counter (Depth) with Overflow/Underflow detection;
//               a Call at full depth or a Ret at empty skips all stack
//               traffic and completes in one cycle.
//   undefined : no counter; Depth/Overflow/Underflow read 0 and every
//               request performs full stack traffic.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   Reset        in   1   asynchronous active-high reset (shared with Stack)
//   Call         in   1   push request, sampled only while Busy=0
//   Ret          in   1   pop request, sampled only while Busy=0 (Call wins)
//   RetAddr      in  16   return address, captured on the accepting edge
//   Busy         out  1   operation in progress
//   Done         out  1   one-cycle completion pulse
//   PopAddr      out 16   last popped return address
//   Depth        out  8   current frame count
//   Overflow     out  1   sticky: Call made at full depth
//   Underflow    out  1   sticky: Ret made at empty
//   StackWrite   out  1   push strobe to Stack
//   StackRead    out  1   pop strobe to Stack
//   StackDataOut out  8   byte to Stack.Datain
//   StackDataIn  in   8   byte from Stack.Dataout
//
// Parameters:
//   MAX_NEST     maximum number of outstanding frames (1..255)
// ---------------------------------------------------------------------------
module call_return_unit #(
    parameter int MAX_NEST = 128
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Call,
    input  logic        Ret,
    input  logic [15:0] RetAddr,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] PopAddr,
    output logic [7:0]  Depth,
    output logic        Overflow,
    output logic        Underflow,
    output logic        StackWrite,
    output logic        StackRead,
    output logic [7:0]  StackDataOut,
    input  logic [7:0]  StackDataIn
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PUSH_LO = 3'd1;
    localparam logic [2:0] PUSH_HI = 3'd2;
    localparam logic [2:0] POP_HI  = 3'd3;
    localparam logic [2:0] CAP_HI  = 3'd4;
    localparam logic [2:0] POP_LO  = 3'd5;
    localparam logic [2:0] CAP_LO  = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    // Depth is an 8-bit port, so the frame limit must fit in it.
    if (MAX_NEST < 1 || MAX_NEST > 255) begin : g_max_nest_range
        $error("call_return_unit: MAX_NEST must be in 1..255");
    end

    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic [15:0] addr_reg;
    logic [15:0] addr_next;
    logic        busy_reg;
    logic        done_reg;
    logic        stack_write_reg;
    logic        stack_read_reg;
    logic [7:0]  stack_data_out_reg;
    logic [15:0] pop_addr_reg;
    logic        can_push;
    logic        can_pop;

`ifdef CRU_DEPTH_CHECK_EN
    localparam logic [8:0] MAX_NEST_W = 9'(MAX_NEST);

    logic [7:0] depth_reg;
    logic       overflow_reg;
    logic       underflow_reg;

    assign can_push = ({1'b0, depth_reg} < MAX_NEST_W);
    assign can_pop  = (depth_reg != 8'd0);

    // The frame only counts once both bytes are on the stack, and is only
    // released once both bytes have been captured.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            depth_reg     <= 8'd0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (state_reg == PUSH_HI) begin
                depth_reg <= depth_reg + 8'd1;
            end else if (state_reg == CAP_LO) begin
                depth_reg <= depth_reg - 8'd1;
            end
            if (state_reg == IDLE && Call && !can_push) begin
                overflow_reg <= 1'b1;
            end
            if (state_reg == IDLE && !Call && Ret && !can_pop) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign Depth     = depth_reg;
    assign Overflow  = overflow_reg;
    assign Underflow = underflow_reg;
`else
    assign can_push  = 1'b1;
    assign can_pop   = 1'b1;
    assign Depth     = 8'd0;
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                if (Call) begin
                    addr_next  = RetAddr;
                    state_next = can_push ? PUSH_LO : DONE;
                end else if (Ret) begin
                    state_next = can_pop ? POP_HI : DONE;
                end
            end
            PUSH_LO: state_next = PUSH_HI;
            PUSH_HI: state_next = DONE;
            POP_HI:  state_next = CAP_HI;
            CAP_HI:  state_next = POP_LO;
            POP_LO:  state_next = CAP_LO;
            CAP_LO:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state they describe without any input-to-output path.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_reg          <= IDLE;
            addr_reg           <= 16'd0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            stack_write_reg    <= 1'b0;
            stack_read_reg     <= 1'b0;
            stack_data_out_reg <= 8'd0;
            pop_addr_reg       <= 16'd0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            busy_reg        <= (state_next != IDLE);
            done_reg        <= (state_next == DONE);
            stack_write_reg <= (state_next == PUSH_LO) || (state_next == PUSH_HI);
            stack_read_reg  <= (state_next == POP_HI) || (state_next == POP_LO);
            if (state_next == PUSH_LO) begin
                stack_data_out_reg <= addr_next[7:0];
            end else if (state_next == PUSH_HI) begin
                stack_data_out_reg <= addr_next[15:8];
            end else begin
                stack_data_out_reg <= 8'd0;
            end
            // Stack.Dataout becomes valid on the edge ending a read strobe
            // and is sampled one edge later, i.e. while in the CAP states.
            if (state_reg == CAP_HI) begin
                pop_addr_reg[15:8] <= StackDataIn;
            end
            if (state_reg == CAP_LO) begin
                pop_addr_reg[7:0] <= StackDataIn;
            end
        end
    end

    assign Busy         = busy_reg;
    assign Done         = done_reg;
    assign PopAddr      = pop_addr_reg;
    assign StackWrite   = stack_write_reg;
    assign StackRead    = stack_read_reg;
    assign StackDataOut = stack_data_out_reg;

endmodule

// File: tb/tb_call_return_unit.sv
// ---------------------------------------------------------------------------
// tb_call_return_unit
//
// Directed bench for call_return_unit with MAX_NEST=2 and a behavioural
// byte stack. Expected stack bytes and completion results are queued when
// an operation is issued and checked by a monitor as the DUT produces them.
// Expectations follow the CRU_DEPTH_CHECK_EN build setting.
// ---------------------------------------------------------------------------
module tb_call_return_unit;

`ifdef CRU_DEPTH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] pop;
        logic [7:0]  depth;
        logic        ovf;
        logic        unf;
    } res_t;

    logic        clk;
    logic        Reset;
    logic        Call;
    logic        Ret;
    logic [15:0] RetAddr;
    logic        Busy;
    logic        Done;
    logic [15:0] PopAddr;
    logic [7:0]  Depth;
    logic        Overflow;
    logic        Underflow;
    logic        StackWrite;
    logic        StackRead;
    logic [7:0]  StackDataOut;
    logic [7:0]  StackDataIn;

    int tests = 0;
    int fails = 0;
    int n_writes = 0;
    int n_reads = 0;

    logic [7:0] exp_wr_q[$];
    res_t       done_q[$];

    call_return_unit #(.MAX_NEST(2)) dut (
        .clk(clk), .Reset(Reset), .Call(Call), .Ret(Ret), .RetAddr(RetAddr),
        .Busy(Busy), .Done(Done), .PopAddr(PopAddr), .Depth(Depth),
        .Overflow(Overflow), .Underflow(Underflow),
        .StackWrite(StackWrite), .StackRead(StackRead),
        .StackDataOut(StackDataOut), .StackDataIn(StackDataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: popping an empty stack returns 0.
    logic [7:0] mem [256];
    logic [8:0] sp;
    logic [7:0] dout;
    assign StackDataIn = dout;

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sp   <= 9'd0;
            dout <= 8'd0;
        end else if (StackWrite) begin
            mem[sp[7:0]] <= StackDataOut;
            sp           <= sp + 9'd1;
        end else if (StackRead) begin
            if (sp != 9'd0) begin
                dout <= mem[sp[7:0] - 8'd1];
                sp   <= sp - 9'd1;
            end else begin
                dout <= 8'd0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_push(input logic [15:0] a);
        exp_wr_q.push_back(a[7:0]);
        exp_wr_q.push_back(a[15:8]);
    endtask

    task automatic expect_done(input logic [15:0] p, input logic [7:0] d, input logic o, input logic u);
        res_t r;
        r.pop = p; r.depth = d; r.ovf = o; r.unf = u;
        done_q.push_back(r);
    endtask

    // Monitor: stack bytes and completion results against the scoreboard.
    always @(negedge clk) begin
        if (!Reset) begin
            check("strobe_exclusive", 32'(StackWrite & StackRead), 32'd0);
            if (StackWrite) begin
                n_writes++;
                check("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    check("write_byte", 32'(StackDataOut), 32'(exp_wr_q.pop_front()));
                end
            end else begin
                check("dataout_idle", 32'(StackDataOut), 32'd0);
            end
            if (StackRead) n_reads++;
            if (Done) begin
                check("done_expected", 32'(done_q.size() != 0), 32'd1);
                check("busy_at_done", 32'(Busy), 32'd1);
                if (done_q.size() != 0) begin
                    res_t r;
                    r = done_q.pop_front();
                    $display("[TB] done: PopAddr=%h Depth=%0d Ovf=%b Unf=%b", PopAddr, Depth, Overflow, Underflow);
                    check("pop_addr", 32'(PopAddr), 32'(r.pop));
                    check("depth", 32'(Depth), 32'(r.depth));
                    check("overflow", 32'(Overflow), 32'(r.ovf));
                    check("underflow", 32'(Underflow), 32'(r.unf));
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        exp_wr_q.delete();
        done_q.delete();
    endtask

    // Issue one request at a negedge, wait for Done with a cycle bound and
    // check latency and strobe counts. Returns at the first IDLE negedge.
    task automatic do_op(input logic c, input logic r, input logic [15:0] a,
                         input int exp_lat, input int exp_w, input int exp_r, input string tag);
        int lat;
        n_writes = 0;
        n_reads  = 0;
        Call = c; Ret = r; RetAddr = a;
        @(posedge clk);
        @(negedge clk);
        Call = 1'b0; Ret = 1'b0;
        check({tag, "_busy"}, 32'(Busy), 32'd1);
        lat = 1;
        while (!Done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        #1;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_writes"}, 32'(n_writes), 32'(exp_w));
        check({tag, "_reads"}, 32'(n_reads), 32'(exp_r));
        check({tag, "_wr_queue_drained"}, 32'(exp_wr_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int dones;
        Reset = 1'b0; Call = 1'b0; Ret = 1'b0; RetAddr = 16'h0;

        // Reset values
        reset_dut();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_popaddr", 32'(PopAddr), 32'd0);
        check("rst_depth", 32'(Depth), 32'd0);
        check("rst_ovf", 32'(Overflow), 32'd0);
        check("rst_unf", 32'(Underflow), 32'd0);
        check("rst_wr", 32'(StackWrite), 32'd0);
        check("rst_rd", 32'(StackRead), 32'd0);
        check("rst_dout", 32'(StackDataOut), 32'd0);

        // Single call
        expect_push(16'h1234);
        expect_done(16'h0, CHK ? 8'd1 : 8'd0, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 16'h1234, 3, 2, 0, "call_1234");

        // Nested call / return
        reset_dut();
        expect_push(16'hA1B2);
        expect_done(16'h0, CHK ? 8'd1 : 8'd0, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 16'hA1B2, 3, 2, 0, "call_a1b2");
        expect_push(16'hC3D4);
        expect_done(16'h0, CHK ? 8'd2 : 8'd0, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 16'hC3D4, 3, 2, 0, "call_c3d4");
        expect_done(16'hC3D4, CHK ? 8'd1 : 8'd0, 1'b0, 1'b0);
        do_op(1'b0, 1'b1, 16'h0, 5, 0, 2, "ret_c3d4");
        expect_done(16'hA1B2, 8'd0, 1'b0, 1'b0);
        do_op(1'b0, 1'b1, 16'h0, 5, 0, 2, "ret_a1b2");

        // Ret at empty
        reset_dut();
        expect_done(16'h0, 8'd0, 1'b0, CHK);
        do_op(1'b0, 1'b1, 16'hFFFF, CHK ? 1 : 5, 0, CHK ? 0 : 2, "ret_empty");

        // Overflow with MAX_NEST=2
        reset_dut();
        expect_push(16'h1111);
        expect_done(16'h0, CHK ? 8'd1 : 8'd0, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 16'h1111, 3, 2, 0, "ovf_call1");
        expect_push(16'h2222);
        expect_done(16'h0, CHK ? 8'd2 : 8'd0, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 16'h2222, 3, 2, 0, "ovf_call2");
        if (!CHK) expect_push(16'h3333);
        expect_done(16'h0, CHK ? 8'd2 : 8'd0, CHK, 1'b0);
        do_op(1'b1, 1'b0, 16'h3333, CHK ? 1 : 3, CHK ? 0 : 2, 0, "ovf_call3");
        expect_done(CHK ? 16'h2222 : 16'h3333, CHK ? 8'd1 : 8'd0, CHK, 1'b0);
        do_op(1'b0, 1'b1, 16'h0, 5, 0, 2, "ovf_ret");

        // Call and Ret together, Ret held through Busy
        reset_dut();
        expect_push(16'h5AC3);
        expect_done(16'h0, CHK ? 8'd1 : 8'd0, 1'b0, 1'b0);
        expect_done(16'h5AC3, 8'd0, 1'b0, 1'b0);
        n_writes = 0; n_reads = 0;
        Call = 1'b1; Ret = 1'b1; RetAddr = 16'h5AC3;
        @(posedge clk);
        @(negedge clk);
        Call = 1'b0;
        lat = 1; dones = 0;
        while (dones < 2 && lat < 40) begin
            if (Done) begin
                dones++;
                if (dones == 1) check("both_first_done_lat", 32'(lat), 32'd3);
            end
            if (dones < 2) begin
                if (lat == 5) Ret = 1'b0;
                @(negedge clk);
                lat++;
            end
        end
        Ret = 1'b0;
        #1;
        check("both_second_done_lat", 32'(lat), 32'd9);
        check("both_writes", 32'(n_writes), 32'd2);
        check("both_reads", 32'(n_reads), 32'd2);
        @(negedge clk);

        // Reset during PUSH_HI discards the frame
        reset_dut();
        expect_push(16'h0BEE);
        Call = 1'b1; RetAddr = 16'h0BEE;
        @(posedge clk);
        @(negedge clk);
        Call = 1'b0;
        @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_wr", 32'(StackWrite), 32'd0);
        check("midrst_dout", 32'(StackDataOut), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_depth", 32'(Depth), 32'd0);
        exp_wr_q.delete();
        done_q.delete();
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        expect_done(16'h0, 8'd0, 1'b0, CHK);
        do_op(1'b0, 1'b1, 16'h0, CHK ? 1 : 5, 0, CHK ? 0 : 2, "midrst_ret");

        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
